// File: rtl/knn_dist_sort_pkg.sv
// Shared types and helpers for the KNN distance/sort datapath.
package knn_dist_sort_pkg;

  // Top-level control states; encodings are fixed so software-visible debug taps stay stable.
  typedef enum logic [1:0] {
    KnnIdle  = 2'd0,
    KnnRun   = 2'd1,
    KnnDrain = 2'd2,
    KnnDone  = 2'd3
  } knn_state_e;

  // Width of an unsigned squared distance for signed coordinates of width dw.
  function automatic int unsigned knn_dist_w(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/knn_dist_sort_sqdist.sv
// Two-stage pipeline: stage 1 forms dx/dy, stage 2 forms dx*dx + dy*dy.
// A flush clears both valid bits so in-flight points never reach the list.
module knn_dist_sort_sqdist
  import knn_dist_sort_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LABEL_W = 8,
  localparam int unsigned DIST_W = knn_dist_w(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  pt_x,
  input  logic [DATA_W-1:0]  pt_y,
  input  logic [LABEL_W-1:0] pt_label,
  input  logic [DATA_W-1:0]  test_x,
  input  logic [DATA_W-1:0]  test_y,
  output logic               busy,
  output logic               out_valid,
  output logic [DIST_W-1:0]  out_dist,
  output logic [LABEL_W-1:0] out_label
);

  logic signed [DATA_W:0]     dx_d, dx_q, dy_d, dy_q;
  logic [LABEL_W-1:0]         lab1_q, lab2_q;
  logic                       v1_d, v1_q, v2_d, v2_q;
  logic signed [2*DATA_W+1:0] sq_x, sq_y;
  logic [DIST_W-1:0]          dist_d, dist_q;

  // Next-state for both stages; differences are sign-extended by one bit so they never wrap.
  always_comb begin
    dx_d   = $signed({pt_x[DATA_W-1], pt_x}) - $signed({test_x[DATA_W-1], test_x});
    dy_d   = $signed({pt_y[DATA_W-1], pt_y}) - $signed({test_y[DATA_W-1], test_y});
    v1_d   = in_valid & ~flush;
    v2_d   = v1_q & ~flush;
    sq_x   = dx_q * dx_q;
    sq_y   = dy_q * dy_q;
    // Each square is at most 2^(2*DATA_W); the sum fits DIST_W bits exactly.
    dist_d = DIST_W'(sq_x) + DIST_W'(sq_y);
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q   <= '0;
      dy_q   <= '0;
      lab1_q <= '0;
      v1_q   <= 1'b0;
      dist_q <= '0;
      lab2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (in_valid) begin
        dx_q   <= dx_d;
        dy_q   <= dy_d;
        lab1_q <= pt_label;
      end
      if (v1_q) begin
        dist_q <= dist_d;
        lab2_q <= lab1_q;
      end
    end
  end

  assign busy      = v1_q | v2_q;
  assign out_valid = v2_q;
  assign out_dist  = dist_q;
  assign out_label = lab2_q;

endmodule

// File: rtl/knn_dist_sort.sv
// KNN datapath core: latches a test point, streams reference points through the
// squared-distance pipeline and keeps a sorted list of the K nearest.
module knn_dist_sort
  import knn_dist_sort_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned K       = 10,
  localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned DIST_W = knn_dist_w(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  test_x,
  input  logic [DATA_W-1:0]  test_y,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [DATA_W-1:0]  pt_x,
  input  logic [DATA_W-1:0]  pt_y,
  input  logic [LABEL_W-1:0] pt_label,
  input  logic               pt_last,
  output logic               busy,
  output logic               done,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [DIST_W-1:0]  rd_dist,
  output logic [LABEL_W-1:0] rd_label,
  output logic               rd_valid,
  output logic [31:0]        n_proc
);

  knn_state_e         state_d, state_q;
  logic [DATA_W-1:0]  tx_d, tx_q, ty_d, ty_q;
  logic [31:0]        n_proc_d, n_proc_q;
  logic               accept;
  logic               pipe_busy, ins_valid;
  logic [DIST_W-1:0]  ins_dist;
  logic [LABEL_W-1:0] ins_label;

  logic [K-1:0]       lst_valid_d, lst_valid_q;
  logic [DIST_W-1:0]  lst_dist_d [K];
  logic [DIST_W-1:0]  lst_dist_q [K];
  logic [LABEL_W-1:0] lst_label_d [K];
  logic [LABEL_W-1:0] lst_label_q [K];
  logic [K-1:0]       le;

  logic               rd_in_range;
  logic [IDX_W-1:0]   rd_sel;

  // A start in the same cycle as a transfer wins; the point is dropped.
  assign pt_ready = (state_q == KnnRun);
  assign accept   = pt_valid & pt_ready & ~start;

  knn_dist_sort_sqdist #(
    .DATA_W  (DATA_W),
    .LABEL_W (LABEL_W)
  ) u_sqdist (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .in_valid  (accept),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_label  (pt_label),
    .test_x    (tx_q),
    .test_y    (ty_q),
    .busy      (pipe_busy),
    .out_valid (ins_valid),
    .out_dist  (ins_dist),
    .out_label (ins_label)
  );

  // FSM next-state, test point latch and accepted-point counter.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    n_proc_d = n_proc_q;
    if (start) begin
      state_d  = KnnRun;
      tx_d     = test_x;
      ty_d     = test_y;
      n_proc_d = '0;
    end else begin
      unique case (state_q)
        KnnIdle:  state_d = KnnIdle;
        KnnRun:   if (accept && pt_last) state_d = KnnDrain;
        KnnDrain: if (!pipe_busy) state_d = KnnDone;
        KnnDone:  state_d = KnnDone;
        default:  state_d = KnnIdle;
      endcase
      if (accept && (n_proc_q != '1)) n_proc_d = n_proc_q + 32'd1;
    end
  end

  // Parallel insertion: le is a thermometer over the sorted valid prefix, so the first
  // clear bit is the insert position; ties stay ahead of the newcomer.
  always_comb begin
    lst_valid_d = lst_valid_q;
    lst_dist_d  = lst_dist_q;
    lst_label_d = lst_label_q;
    for (int unsigned i = 0; i < K; i++) begin
      le[i] = lst_valid_q[i] && (lst_dist_q[i] <= ins_dist);
    end
    if (start) begin
      lst_valid_d = '0;
    end else if (ins_valid) begin
      if (!le[0]) begin
        lst_valid_d[0] = 1'b1;
        lst_dist_d[0]  = ins_dist;
        lst_label_d[0] = ins_label;
      end
      for (int unsigned i = 1; i < K; i++) begin
        if (!le[i]) begin
          if (le[i-1]) begin
            lst_valid_d[i] = 1'b1;
            lst_dist_d[i]  = ins_dist;
            lst_label_d[i] = ins_label;
          end else begin
            lst_valid_d[i] = lst_valid_q[i-1];
            lst_dist_d[i]  = lst_dist_q[i-1];
            lst_label_d[i] = lst_label_q[i-1];
          end
        end
      end
    end
  end

  // State, test point, counter and list registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= KnnIdle;
      tx_q        <= '0;
      ty_q        <= '0;
      n_proc_q    <= '0;
      lst_valid_q <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        lst_dist_q[i]  <= '0;
        lst_label_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      n_proc_q    <= n_proc_d;
      lst_valid_q <= lst_valid_d;
      lst_dist_q  <= lst_dist_d;
      lst_label_q <= lst_label_d;
    end
  end

  // Combinational read port; out-of-range or empty entries read as all zeros.
  always_comb begin
    rd_in_range = (32'(rd_idx) < K);
    rd_sel      = rd_in_range ? rd_idx : '0;
    rd_valid    = 1'b0;
    rd_dist     = '0;
    rd_label    = '0;
    if (rd_in_range && lst_valid_q[rd_sel]) begin
      rd_valid = 1'b1;
      rd_dist  = lst_dist_q[rd_sel];
      rd_label = lst_label_q[rd_sel];
    end
  end

  assign busy   = (state_q == KnnRun) || (state_q == KnnDrain);
  assign done   = (state_q == KnnDone);
  assign n_proc = n_proc_q;

endmodule
